// File: rtl/ife_dispatch_arbiter_if.sv
// Bundle of IFE-side handshake, core status/dispatch and commit report signals
// for the block dispatcher. The master side is the IFE plus the core array;
// the slave side is the dispatcher itself.
interface ife_dispatch_arbiter_if #(
  parameter int N_CORES     = 4,
  parameter int BLOCK_WORDS = 4,
  parameter int ID_W        = 8,
  parameter int DEPTH       = 8
);
  logic                         in_valid;
  logic                         in_ready;
  logic [ID_W-1:0]              in_id;
  logic [BLOCK_WORDS*32-1:0]    in_data;
  logic                         in_serial;
  logic [N_CORES-1:0]           core_busy;
  logic [N_CORES-1:0]           core_commit;
  logic [N_CORES-1:0]           disp_valid;
  logic [ID_W-1:0]              disp_id;
  logic [BLOCK_WORDS*32-1:0]    disp_data;
  logic                         disp_serial;
  logic                         commit_valid;
  logic [ID_W-1:0]              commit_id;
  logic [$clog2(N_CORES)-1:0]   commit_core;
  logic                         commit_serial;
  logic [$clog2(DEPTH):0]       fifo_count;
  logic                         err_spurious;

  modport master (
    output in_valid, in_id, in_data, in_serial, core_busy, core_commit,
    input  in_ready, disp_valid, disp_id, disp_data, disp_serial,
           commit_valid, commit_id, commit_core, commit_serial,
           fifo_count, err_spurious
  );

  modport slave (
    input  in_valid, in_id, in_data, in_serial, core_busy, core_commit,
    output in_ready, disp_valid, disp_id, disp_data, disp_serial,
           commit_valid, commit_id, commit_core, commit_serial,
           fifo_count, err_spurious
  );
endinterface

// File: rtl/ife_dispatch_arbiter.sv
// Block dispatcher between the IFE and N_CORES nebula cores: buffered input
// queue, round-robin dispatch of parallel blocks, barrier-fenced dispatch of
// serial blocks to core 0, and one-per-cycle commit reporting.
//
// state  | meaning
// RUN    | dispatch parallel heads round-robin to free cores
// FENCE  | serial head waiting for every core to drain
// SERIAL | serial block running on core 0, waiting for its commit report
module ife_dispatch_arbiter #(
  parameter int N_CORES     = 4,
  parameter int BLOCK_WORDS = 4,
  parameter int ID_W        = 8,
  parameter int DEPTH       = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  ife_dispatch_arbiter_if.slave  bus
);
  localparam int DW = BLOCK_WORDS * 32;
  localparam int EW = ID_W + DW + 1;
  localparam int CW = $clog2(N_CORES);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {RUN, FENCE, SERIAL} state_t;

  state_t            state, state_nxt;
  logic [EW-1:0]     mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count;
  logic              full, empty, push;
  logic [EW-1:0]     head;
  logic [ID_W-1:0]   head_id;
  logic [DW-1:0]     head_data;
  logic              head_ser;
  logic [N_CORES-1:0] outstanding, pend, free, ser_q;
  logic [ID_W-1:0]   id_q [N_CORES];
  logic [CW-1:0]     rr, rr_nxt, disp_core, rep_core;
  logic              disp_go, rep_go;

  assign full           = (count == (AW+1)'(DEPTH));
  assign empty          = (count == '0);
  assign bus.in_ready   = rst_n & ~full;
  assign push           = bus.in_valid & bus.in_ready;
  assign bus.fifo_count = count;
  assign head           = mem[rd_ptr];
  assign head_id        = head[EW-1 -: ID_W];
  assign head_data      = head[DW:1];
  assign head_ser       = head[0];
  // A core holding an unreported commit is not free, so id_q/ser_q stay valid.
  assign free           = ~bus.core_busy & ~outstanding & ~pend;

  // State and round-robin pointer registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= RUN;
      rr    <= '0;
    end else begin
      state <= state_nxt;
      rr    <= rr_nxt;
    end
  end

  // Dispatch decision: round-robin scan in RUN, drain-then-core-0 in FENCE.
  always_comb begin
    state_nxt = state;
    disp_go   = 1'b0;
    disp_core = '0;
    rr_nxt    = rr;
    unique case (state)
      RUN: begin
        if (!empty) begin
          if (head_ser) begin
            state_nxt = FENCE;
          end else begin
            // Downward walk so the smallest offset from rr wins.
            for (int off = N_CORES - 1; off >= 0; off--) begin
              if (free[(int'(rr) + off) % N_CORES]) begin
                disp_go   = 1'b1;
                disp_core = CW'((int'(rr) + off) % N_CORES);
              end
            end
            if (disp_go) rr_nxt = CW'((int'(disp_core) + 1) % N_CORES);
          end
        end
      end
      FENCE: begin
        if (!empty && (&free)) begin
          disp_go   = 1'b1;
          disp_core = '0;
          state_nxt = SERIAL;
        end
      end
      SERIAL: begin
        if (bus.commit_valid && (bus.commit_core == '0)) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  // Lowest-index pending commit is the one reported this cycle.
  always_comb begin
    rep_go   = 1'b0;
    rep_core = '0;
    for (int j = N_CORES - 1; j >= 0; j--) begin
      if (pend[j]) begin
        rep_go   = 1'b1;
        rep_core = CW'(j);
      end
    end
  end

  // Queue storage; in_ready is low in reset, so no write happens then.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {bus.in_id, bus.in_data, bus.in_serial};
  end

  // Queue pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)    wr_ptr <= wr_ptr + 1'b1;
      if (disp_go) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(disp_go);
    end
  end

  // Registered dispatch strobe and payload.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.disp_valid  <= '0;
      bus.disp_id     <= '0;
      bus.disp_data   <= '0;
      bus.disp_serial <= 1'b0;
    end else begin
      bus.disp_valid <= disp_go ? (N_CORES'(1) << disp_core) : '0;
      if (disp_go) begin
        bus.disp_id     <= head_id;
        bus.disp_data   <= head_data;
        bus.disp_serial <= head_ser;
      end
    end
  end

  // Per-core tracking, commit capture, commit report and spurious flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      outstanding       <= '0;
      pend              <= '0;
      ser_q             <= '0;
      for (int i = 0; i < N_CORES; i++) id_q[i] <= '0;
      bus.commit_valid  <= 1'b0;
      bus.commit_id     <= '0;
      bus.commit_core   <= '0;
      bus.commit_serial <= 1'b0;
      bus.err_spurious  <= 1'b0;
    end else begin
      bus.commit_valid <= rep_go;
      if (rep_go) begin
        bus.commit_id     <= id_q[rep_core];
        bus.commit_core   <= rep_core;
        bus.commit_serial <= ser_q[rep_core];
      end
      for (int i = 0; i < N_CORES; i++) begin
        if (rep_go && (rep_core == CW'(i))) pend[i] <= 1'b0;
        if (bus.core_commit[i]) begin
          if (outstanding[i]) begin
            outstanding[i] <= 1'b0;
            pend[i]        <= 1'b1;
          end else begin
            bus.err_spurious <= 1'b1;
          end
        end
        if (disp_go && (disp_core == CW'(i))) begin
          outstanding[i] <= 1'b1;
          id_q[i]        <= head_id;
          ser_q[i]       <= head_ser;
        end
      end
    end
  end
endmodule

// File: tb/tb_ife_dispatch_arbiter.sv
// Bench for ife_dispatch_arbiter: directed scenarios followed by a randomized
// run, all checked each cycle against a transaction-level queue model.
module tb_ife_dispatch_arbiter;
  localparam int N  = 4;
  localparam int BW = 4;
  localparam int IW = 8;
  localparam int D  = 8;

  typedef struct {
    logic [IW-1:0]      id;
    logic [BW*32-1:0]   data;
    logic               ser;
  } blk_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ife_dispatch_arbiter_if #(.N_CORES(N), .BLOCK_WORDS(BW), .ID_W(IW), .DEPTH(D)) bus ();

  ife_dispatch_arbiter #(.N_CORES(N), .BLOCK_WORDS(BW), .ID_W(IW), .DEPTH(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: queue of blocks, per-core bookkeeping, expected outputs.
  blk_t             q[$];
  bit   [N-1:0]     m_out, m_pend, m_ser;
  logic [IW-1:0]    m_id [N];
  int               m_rr;
  bit               m_barrier, m_live, m_err;
  logic [N-1:0]     e_dv;
  logic [IW-1:0]    e_did, e_cid;
  logic [BW*32-1:0] e_ddata;
  logic             e_dser, e_cv, e_cser;
  logic [1:0]       e_ccore;
  bit               seen [256];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [BW*32-1:0] mk_data(input logic [7:0] id);
    return {4{id, 24'h5A5A5A}};
  endfunction

  // Advance the model across one rising edge using the inputs now driven.
  task automatic model_tick();
    bit   fr [N];
    bit   allfree, go, ready;
    int   k, j;
    blk_t h;
    if (!rst_n) begin
      q.delete();
      m_out = '0; m_pend = '0; m_ser = '0; m_rr = 0;
      m_barrier = 0; m_live = 0; m_err = 0;
      e_dv = '0; e_did = '0; e_ddata = '0; e_dser = 0;
      e_cv = 0; e_cid = '0; e_ccore = '0; e_cser = 0;
      return;
    end
    ready = (q.size() < D);
    allfree = 1;
    for (int i = 0; i < N; i++) begin
      fr[i] = !bus.core_busy[i] && !m_out[i] && !m_pend[i];
      allfree &= fr[i];
    end
    go = 0; k = 0;
    if (m_live) begin
      if (e_cv && e_ccore == 2'd0) m_live = 0;
    end else if (q.size() > 0) begin
      if (m_barrier) begin
        if (allfree) begin go = 1; k = 0; m_barrier = 0; m_live = 1; end
      end else if (q[0].ser) begin
        m_barrier = 1;
      end else begin
        for (int off = 0; off < N && !go; off++)
          if (fr[(m_rr + off) % N]) begin go = 1; k = (m_rr + off) % N; end
        if (go) m_rr = (k + 1) % N;
      end
    end
    j = -1;
    for (int i = N - 1; i >= 0; i--) if (m_pend[i]) j = i;
    e_cv = (j >= 0);
    if (j >= 0) begin
      e_cid = m_id[j]; e_ccore = 2'(j); e_cser = m_ser[j]; m_pend[j] = 0;
    end
    for (int i = 0; i < N; i++)
      if (bus.core_commit[i]) begin
        if (m_out[i]) begin m_out[i] = 0; m_pend[i] = 1; end
        else m_err = 1;
      end
    e_dv = '0;
    if (go) begin
      h = q.pop_front();
      e_dv[k] = 1'b1; e_did = h.id; e_ddata = h.data; e_dser = h.ser;
      m_out[k] = 1; m_id[k] = h.id; m_ser[k] = h.ser;
    end
    if (bus.in_valid && ready) begin
      h.id = bus.in_id; h.data = bus.in_data; h.ser = bus.in_serial;
      q.push_back(h);
    end
  endtask

  task automatic check_all();
    chk("disp_valid",    bus.disp_valid,    e_dv);
    chk("disp_id",       bus.disp_id,       e_did);
    chk("disp_data",     bus.disp_data,     e_ddata);
    chk("disp_serial",   bus.disp_serial,   e_dser);
    chk("commit_valid",  bus.commit_valid,  e_cv);
    chk("commit_id",     bus.commit_id,     e_cid);
    chk("commit_core",   bus.commit_core,   e_ccore);
    chk("commit_serial", bus.commit_serial, e_cser);
    chk("err_spurious",  bus.err_spurious,  m_err);
    chk("fifo_count",    bus.fifo_count,    q.size());
    chk("in_ready",      bus.in_ready,      rst_n && (q.size() < D));
  endtask

  // One clock: model update, edge, check; commit pulses last one cycle.
  task automatic step();
    model_tick();
    @(posedge clk);
    #1;
    check_all();
    if (bus.commit_valid) seen[bus.commit_id] = 1;
    bus.core_commit = '0;
  endtask

  task automatic push(input logic [7:0] id, input logic ser);
    bus.in_valid = 1; bus.in_id = id; bus.in_data = mk_data(id); bus.in_serial = ser;
    step();
    bus.in_valid = 0;
  endtask

  task automatic wait_disp(input int max, output bit ok);
    ok = 0;
    for (int i = 0; i < max && !ok; i++) begin
      step();
      if (bus.disp_valid != '0) ok = 1;
    end
  endtask

  task automatic wait_commit(input int max, input logic [7:0] id, output bit ok);
    ok = 0;
    for (int i = 0; i < max && !ok; i++) begin
      step();
      if (bus.commit_valid && bus.commit_id == id) ok = 1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit ok;
    rst_n = 0;
    bus.in_valid = 0; bus.in_id = '0; bus.in_data = '0; bus.in_serial = 0;
    bus.core_busy = '0; bus.core_commit = '0;

    // Reset values, then release.
    step(); step();
    chk("rst_in_ready", bus.in_ready, 1'b0);
    chk("rst_disp_valid", bus.disp_valid, 4'b0000);
    rst_n = 1;
    step();
    chk("rel_in_ready", bus.in_ready, 1'b1);
    chk("rel_fifo_count", bus.fifo_count, 4'd0);

    // Round-robin over idle cores; fifth block waits for a commit.
    push(8'h10, 0);
    push(8'h11, 0);
    chk("rr0_valid", bus.disp_valid, 4'b0001); chk("rr0_id", bus.disp_id, 8'h10);
    chk("rr0_data", bus.disp_data, mk_data(8'h10));
    push(8'h12, 0);
    chk("rr1_valid", bus.disp_valid, 4'b0010); chk("rr1_id", bus.disp_id, 8'h11);
    push(8'h13, 0);
    chk("rr2_valid", bus.disp_valid, 4'b0100); chk("rr2_id", bus.disp_id, 8'h12);
    push(8'h14, 0);
    chk("rr3_valid", bus.disp_valid, 4'b1000); chk("rr3_id", bus.disp_id, 8'h13);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rr_hold_valid", bus.disp_valid, 4'b0000);
      chk("rr_hold_count", bus.fifo_count, 4'd1);
    end
    bus.core_commit = 4'b0100;
    step();
    step();
    chk("c2_valid", bus.commit_valid, 1'b1); chk("c2_id", bus.commit_id, 8'h12);
    chk("c2_core", bus.commit_core, 2'd2);
    step();
    chk("rr4_valid", bus.disp_valid, 4'b0100); chk("rr4_id", bus.disp_id, 8'h14);

    // Simultaneous commits on cores 3 and 1: core 1 reported first.
    bus.core_commit = 4'b1010;
    step();
    step();
    chk("ord1_core", bus.commit_core, 2'd1); chk("ord1_id", bus.commit_id, 8'h11);
    chk("ord1_valid", bus.commit_valid, 1'b1);
    step();
    chk("ord3_core", bus.commit_core, 2'd3); chk("ord3_id", bus.commit_id, 8'h13);
    chk("ord3_valid", bus.commit_valid, 1'b1);
    step();
    chk("ord_done", bus.commit_valid, 1'b0);
    bus.core_commit = 4'b0101;
    step(); step(); step(); step();

    // Serial barrier: P 0x20, S 0x21, P 0x22.
    push(8'h20, 0);
    push(8'h21, 1);
    chk("p20_valid", bus.disp_valid, 4'b1000); chk("p20_id", bus.disp_id, 8'h20);
    push(8'h22, 0);
    step(); step();
    chk("fence_hold", bus.disp_valid, 4'b0000);
    bus.core_commit = 4'b1000;
    step();
    wait_disp(6, ok);
    chk("s21_wait", ok, 1'b1);
    chk("s21_valid", bus.disp_valid, 4'b0001); chk("s21_id", bus.disp_id, 8'h21);
    chk("s21_serial", bus.disp_serial, 1'b1); chk("s21_after_c20", seen[8'h20], 1'b1);
    step(); step();
    chk("serial_hold", bus.disp_valid, 4'b0000);
    bus.core_commit = 4'b0001;
    wait_commit(6, 8'h21, ok);
    chk("c21_wait", ok, 1'b1); chk("c21_serial", bus.commit_serial, 1'b1);
    wait_disp(6, ok);
    chk("p22_wait", ok, 1'b1);
    chk("p22_valid", bus.disp_valid, 4'b0001); chk("p22_id", bus.disp_id, 8'h22);
    chk("p22_after_c21", seen[8'h21], 1'b1);
    bus.core_commit = 4'b0001;
    step(); step(); step();

    // Full queue with every core busy.
    bus.core_busy = 4'b1111;
    for (int i = 0; i < 8; i++) push(8'h30 + 8'(i), 0);
    chk("full_count", bus.fifo_count, 4'd8); chk("full_ready", bus.in_ready, 1'b0);
    push(8'h38, 0);
    chk("full_reject", bus.fifo_count, 4'd8);
    bus.core_busy = 4'b1101;
    step();
    chk("drain_count", bus.fifo_count, 4'd7); chk("drain_ready", bus.in_ready, 1'b1);
    chk("drain_valid", bus.disp_valid, 4'b0010); chk("drain_id", bus.disp_id, 8'h30);

    // Spurious commit is sticky; reset mid-dispatch clears everything.
    bus.core_commit = 4'b0100;
    step();
    chk("spur_set", bus.err_spurious, 1'b1);
    bus.core_busy = 4'b0000;
    bus.core_commit = 4'b0010;
    step(); step();
    chk("spur_sticky", bus.err_spurious, 1'b1);
    rst_n = 0;
    step();
    chk("mrst_err", bus.err_spurious, 1'b0); chk("mrst_count", bus.fifo_count, 4'd0);
    chk("mrst_disp", bus.disp_valid, 4'b0000); chk("mrst_commit", bus.commit_valid, 1'b0);
    rst_n = 1;
    step();
    chk("mrst_ready", bus.in_ready, 1'b1);

    // Randomized traffic against the model, with one reset in the middle.
    for (int c = 0; c < 600; c++) begin
      rst_n = (c != 300);
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.in_id     = 8'($urandom);
      bus.in_data   = {$urandom, $urandom, $urandom, $urandom};
      bus.in_serial = ($urandom_range(0, 7) == 0);
      for (int i = 0; i < N; i++) begin
        bus.core_busy[i]   = ($urandom_range(0, 3) == 0);
        bus.core_commit[i] = (m_out[i] && $urandom_range(0, 2) == 0) ||
                             ($urandom_range(0, 199) == 0);
      end
      step();
    end
    rst_n = 1;
    bus.in_valid = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
